pci_target: RTL and testbench
=============================

# pci_target

PCI bus target (responder) that answers memory read and memory write transactions started by the initiator side of the PCI device. It decodes the address phase against a fixed window, claims the transaction with fast DEVSEL, and moves burst data between the bus and an internal byte-enabled word memory. It handles IRDY wait states, linear bursts and the turnaround cycle. All bus signals are split into in/out/oe so that tristating stays in the top-level device wrapper.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_1000: byte base of the claimed window; must be aligned to MEM_WORDS*4.
- MEM_WORDS, 16: depth of internal memory in 32-bit words; power of two, 2..256.

Ports:
- CLK  in  1  bus clock; all state updates on rising edge.
- RST  in  1  reset; asynchronous, active-high.
- FRAME  in  1  active-low FRAME from bus.
- IRDY  in  1  active-low initiator ready.
- C_BE  in  4  command in address phase; active-low byte enables in data phases.
- AD_IN  in  32  AD bus as seen by the target.
- AD_OUT  out  32  read data driven toward AD.
- AD_OE  out  1  drive enable for AD_OUT.
- TRDY  out  1  active-low target ready.
- TRDY_OE  out  1  drive enable for TRDY.
- DEVSEL  out  1  active-low device select.
- DEVSEL_OE  out  1  drive enable for DEVSEL.
- DONE  out  1  one-cycle pulse after the last data transfer of a claimed transaction.

## Operation
- Commands: 4'b0110 memory read, 4'b0111 memory write. All other commands are ignored.
- FSM states: IDLE, SKIP, WR_DATA, RD_TA, RD_DATA, TURN.
- IDLE: an address phase is FRAME=0 sampled in IDLE.
  - Hit when all hold: command is read or write; AD_IN[1:0]==2'b00; AD_IN lies in [BASE_ADDR, BASE_ADDR+MEM_WORDS*4).
  - On a hit, the word pointer ptr = AD_IN[log2(MEM_WORDS)+1:2].
  - Write hit goes to WR_DATA. Read hit goes to RD_TA. A miss goes to SKIP.
- SKIP: no outputs driven. Return to IDLE when FRAME=1 and IRDY=1 are sampled together.
- WR_DATA:
  - DEVSEL=0 and TRDY=0, both driven.
  - On each edge with IRDY=0 and TRDY=0: write AD_IN into mem[ptr], only the bytes whose C_BE bit is 0; then ptr increments.
  - A transfer with FRAME=1 is the last one and moves the FSM to TURN.
- RD_TA: turnaround cycle. DEVSEL=0 driven; TRDY=1 driven; AD_OE=0. Next state is RD_DATA.
- RD_DATA:
  - AD_OE=1, AD_OUT=mem[ptr], TRDY=0.
  - On a transfer, ptr increments; the next word appears the following cycle with TRDY held low (zero wait state).
  - Last transfer (FRAME=1) moves the FSM to TURN.
- Wait states: IRDY=1 holds ptr, AD_OUT and memory unchanged.
- ptr wraps modulo MEM_WORDS; a burst never leaves the window.
- TURN: DEVSEL=1 and TRDY=1 driven; AD_OE=0; DONE=1. Next state is IDLE, where all OE are 0.
- Memory can be modified only by the bus write path.

## Timing
- Reset values: AD_OUT=0, AD_OE=0, TRDY=1, TRDY_OE=0, DEVSEL=1, DEVSEL_OE=0, DONE=0, FSM=IDLE, all memory words 0.
- Reset acts asynchronously mid-transaction: all OE drop immediately, and a partially written word keeps the bytes already committed.
- Address phase is on edge A.
- Write: DEVSEL and TRDY are low in cycle A+1; the first data can transfer at edge A+2.
- Read: DEVSEL is low in A+1; AD_OE, AD_OUT and TRDY are valid in A+2; the first transfer is at edge A+3.
- DONE is high for exactly the one cycle following the last transfer.
- All outputs are registered, with no combinational path from bus inputs to outputs.

## Structure
- Package pci_pkg holds:
  - CMD_MEM_READ and CMD_MEM_WRITE constants;
  - the target state enum;
  - a window-hit helper function taking base and size.
- Sub-module target_mem holds the MEM_WORDS x 32 register array. Interface:
  - asynchronous read port;
  - single write port with a 4-bit active-high byte-write mask (the inverted C_BE);
  - asynchronous RST clear.

## Test plan
- Single write, then read back: write 32'hDEAD_BEEF to 32'h0000_1008 with C_BE=0000, then read 32'h0000_1008 -> AD_OUT=32'hDEAD_BEEF at A+2, DONE pulse, and TRDY/DEVSEL released in the cycle after DONE.
- Burst write with waits: 4 words 1, 2, 3, 4 from 32'h0000_1000 with IRDY=1 for 2 cycles before word 3 -> mem[0..3]=1..4 and no write during the wait cycles.
- Partial byte enables: mem[5]=32'h1122_3344, then write 32'hAABB_CCDD with C_BE=4'b1010 -> mem[5]=32'h11BB_33DD.
- Misses: address 32'h0000_2000, command 4'b0010, and address 32'h0000_1002 -> DEVSEL_OE stays 0 through the whole transaction and memory is unchanged.
- Wrap: 3-word read burst from word 15 -> data from mem[15], mem[0], mem[1].
- Reset mid-burst: assert RST during the second data phase of a read -> AD_OE, TRDY_OE and DEVSEL_OE are 0 in the same cycle, and the next address phase is decoded normally after RST drops.

Source files
------------

// File: rtl/pci_pkg.sv
// ---------------------------------------------------------------------------
// pci_pkg
// Shared definitions for the PCI memory target: bus command codes, the target
// state encoding and the address-window decode helper.
// ---------------------------------------------------------------------------
package pci_pkg;

  // Bus commands presented on C_BE during the address phase
  localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

  // Target sequencing states
  typedef enum logic [2:0] {
    IDLE,
    SKIP,
    WR_DATA,
    RD_TA,
    RD_DATA,
    TURN
  } target_state_e;

  // True when addr lies in [base, base+size). The compare is done on 33 bits
  // so a window that touches the top of the address space cannot wrap.
  function automatic logic win_hit(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input logic [31:0] size);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + {1'b0, size};
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/pci_target_if.sv
// ---------------------------------------------------------------------------
// pci_target_if
// Bus-side signal bundle of the PCI target. Inputs come from the bus as seen
// by the device; outputs are split into value/enable pairs so the tristate
// buffers live in the device wrapper.
//   FRAME, IRDY   : active-low initiator controls
//   C_BE          : command (address phase) / active-low byte enables (data)
//   AD_IN         : AD bus as seen by the target
//   AD_OUT/AD_OE  : read data and its drive enable
//   TRDY/TRDY_OE  : active-low target ready and its drive enable
//   DEVSEL/_OE    : active-low device select and its drive enable
//   DONE          : one-cycle pulse after the last transfer
// ---------------------------------------------------------------------------
interface pci_target_if;

  logic        FRAME;
  logic        IRDY;
  logic [3:0]  C_BE;
  logic [31:0] AD_IN;
  logic [31:0] AD_OUT;
  logic        AD_OE;
  logic        TRDY;
  logic        TRDY_OE;
  logic        DEVSEL;
  logic        DEVSEL_OE;
  logic        DONE;

  // Initiator side: drives the bus controls, observes the target responses
  modport master (
    output FRAME, IRDY, C_BE, AD_IN,
    input  AD_OUT, AD_OE, TRDY, TRDY_OE, DEVSEL, DEVSEL_OE, DONE
  );

  // Target side
  modport slave (
    input  FRAME, IRDY, C_BE, AD_IN,
    output AD_OUT, AD_OE, TRDY, TRDY_OE, DEVSEL, DEVSEL_OE, DONE
  );

endinterface

// File: rtl/target_mem.sv
// ---------------------------------------------------------------------------
// target_mem
// MEM_WORDS x 32 register array backing the PCI target window.
//   CLK, RST : clock, asynchronous active-high clear of every word
//   raddr_i  : word address of the asynchronous read port
//   rdata_o  : read data
//   we_i     : write strobe
//   waddr_i  : word address of the write port
//   wdata_i  : write data
//   wmask_i  : active-high byte-write mask (bit b enables byte b)
// ---------------------------------------------------------------------------
module target_mem #(
  parameter int MEM_WORDS = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [$clog2(MEM_WORDS)-1:0] raddr_i,
  output logic [31:0]                  rdata_o,
  input  logic                         we_i,
  input  logic [$clog2(MEM_WORDS)-1:0] waddr_i,
  input  logic [31:0]                  wdata_i,
  input  logic [3:0]                   wmask_i
);

  logic [31:0] mem_q [MEM_WORDS];

  // Storage: whole-array clear on reset, otherwise masked byte writes
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pci_target.sv
// ---------------------------------------------------------------------------
// pci_target
// PCI memory target. Decodes memory read/write address phases against a
// fixed window, claims hits with fast DEVSEL and moves linear bursts between
// the bus and an internal word memory, honouring IRDY wait states and the
// read turnaround cycle. Every bus output is registered.
//   CLK : bus clock
//   RST : asynchronous active-high reset
//   bus : pci_target_if slave modport (bus inputs, split output/enable pairs)
// Parameters:
//   BASE_ADDR : byte base of the window, aligned to MEM_WORDS*4
//   MEM_WORDS : memory depth in words, power of two, 2..256
// ---------------------------------------------------------------------------
module pci_target
  import pci_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          MEM_WORDS = 16
) (
  input  logic         CLK,
  input  logic         RST,
  pci_target_if.slave  bus
);

  localparam int          PTR_W     = $clog2(MEM_WORDS);
  localparam logic [31:0] WIN_BYTES = 32'(MEM_WORDS * 4);

  target_state_e state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  logic [31:0] adOut_q, adOut_d;
  logic        adOe_q, adOe_d;
  logic        trdy_q, trdy_d;
  logic        trdyOe_q, trdyOe_d;
  logic        devsel_q, devsel_d;
  logic        devselOe_q, devselOe_d;
  logic        done_q, done_d;

  logic        addrHit;
  logic        xfer;
  logic        memWe;
  logic [31:0] memRdata;

  // Word memory; reads follow the next-state pointer so the following word
  // is already registered onto AD_OUT when a transfer completes.
  target_mem #(
    .MEM_WORDS (MEM_WORDS)
  ) u_mem (
    .CLK     (CLK),
    .RST     (RST),
    .raddr_i (ptr_d),
    .rdata_o (memRdata),
    .we_i    (memWe),
    .waddr_i (ptr_q),
    .wdata_i (bus.AD_IN),
    .wmask_i (~bus.C_BE)
  );

  // Address-phase decode: supported command, dword aligned, inside window
  always_comb begin
    addrHit = ((bus.C_BE == CMD_MEM_READ) || (bus.C_BE == CMD_MEM_WRITE))
              && (bus.AD_IN[1:0] == 2'b00)
              && win_hit(bus.AD_IN, BASE_ADDR, WIN_BYTES);
  end

  // A data transfer completes on an edge where both ready lines are low
  assign xfer = !bus.IRDY && !trdy_q;

  // State register and registered bus outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      adOut_q    <= '0;
      adOe_q     <= 1'b0;
      trdy_q     <= 1'b1;
      trdyOe_q   <= 1'b0;
      devsel_q   <= 1'b1;
      devselOe_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      adOut_q    <= adOut_d;
      adOe_q     <= adOe_d;
      trdy_q     <= trdy_d;
      trdyOe_q   <= trdyOe_d;
      devsel_q   <= devsel_d;
      devselOe_q <= devselOe_d;
      done_q     <= done_d;
    end
  end

  // Next-state, pointer and write-strobe logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    memWe   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.FRAME) begin
          if (addrHit) begin
            ptr_d   = bus.AD_IN[PTR_W+1:2];
            state_d = (bus.C_BE == CMD_MEM_WRITE) ? WR_DATA : RD_TA;
          end else begin
            state_d = SKIP;
          end
        end
      end
      SKIP: begin
        if (bus.FRAME && bus.IRDY) begin
          state_d = IDLE;
        end
      end
      WR_DATA: begin
        if (xfer) begin
          memWe = 1'b1;
          ptr_d = ptr_q + PTR_W'(1);
          if (bus.FRAME) begin
            state_d = TURN;
          end
        end
      end
      RD_TA: begin
        state_d = RD_DATA;
      end
      RD_DATA: begin
        if (xfer) begin
          ptr_d = ptr_q + PTR_W'(1);
          if (bus.FRAME) begin
            state_d = TURN;
          end
        end
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values are a function of the state being entered, which is what
  // makes them registered yet aligned to the cycle they describe.
  always_comb begin
    adOut_d    = adOut_q;
    adOe_d     = 1'b0;
    trdy_d     = 1'b1;
    trdyOe_d   = 1'b0;
    devsel_d   = 1'b1;
    devselOe_d = 1'b0;
    done_d     = 1'b0;
    case (state_d)
      WR_DATA: begin
        trdy_d     = 1'b0;
        trdyOe_d   = 1'b1;
        devsel_d   = 1'b0;
        devselOe_d = 1'b1;
      end
      RD_TA: begin
        trdyOe_d   = 1'b1;
        devsel_d   = 1'b0;
        devselOe_d = 1'b1;
      end
      RD_DATA: begin
        adOut_d    = memRdata;
        adOe_d     = 1'b1;
        trdy_d     = 1'b0;
        trdyOe_d   = 1'b1;
        devsel_d   = 1'b0;
        devselOe_d = 1'b1;
      end
      TURN: begin
        trdyOe_d   = 1'b1;
        devselOe_d = 1'b1;
        done_d     = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.AD_OUT    = adOut_q;
  assign bus.AD_OE     = adOe_q;
  assign bus.TRDY      = trdy_q;
  assign bus.TRDY_OE   = trdyOe_q;
  assign bus.DEVSEL    = devsel_q;
  assign bus.DEVSEL_OE = devselOe_q;
  assign bus.DONE      = done_q;

endmodule

// File: tb/tb_pci_target.sv
// ---------------------------------------------------------------------------
// tb_pci_target
// Self-checking bench for pci_target. Acts as the PCI initiator, keeps a
// word-array model of the target window and checks bus timing and data.
// ---------------------------------------------------------------------------
module tb_pci_target;
  import pci_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          WORDS = 16;

  logic CLK = 1'b0;
  logic RST;

  pci_target_if bus();

  pci_target #(
    .BASE_ADDR (BASE),
    .MEM_WORDS (WORDS)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] model   [WORDS];
  logic [31:0] wrData  [16];
  logic [3:0]  wrBe    [16];
  int          waitBuf [16];
  logic [31:0] rdBuf   [16];
  logic        rdOe    [16];

  int   cyc;
  int   trdyLat;
  int   devLat;
  bit   anyOe;
  bit   timedOut;
  logic doneA, doneB, devA, devOeA, devOeB, trdyOeB, adOeB;

  // Advance to the next falling edge and record first-seen response timing
  task automatic tick();
    @(negedge CLK);
    cyc++;
    if (trdyLat < 0 && bus.TRDY_OE === 1'b1 && bus.TRDY === 1'b0) trdyLat = cyc;
    if (devLat < 0 && bus.DEVSEL_OE === 1'b1 && bus.DEVSEL === 1'b0) devLat = cyc;
    if (bus.DEVSEL_OE === 1'b1 || bus.TRDY_OE === 1'b1 || bus.AD_OE === 1'b1) anyOe = 1'b1;
  endtask

  // Address phase; returns at the falling edge of cycle A+1
  task automatic addrPhase(input logic [31:0] addr, input logic [3:0] cmd);
    @(negedge CLK);
    bus.FRAME = 1'b0;
    bus.IRDY  = 1'b1;
    bus.C_BE  = cmd;
    bus.AD_IN = addr;
    cyc = 0; trdyLat = -1; devLat = -1; anyOe = 1'b0; timedOut = 1'b0;
    tick();
  endtask

  // Claimed burst using wrData/wrBe/waitBuf; read data lands in rdBuf
  task automatic applyBurst(input logic [31:0] addr, input bit isWrite, input int n);
    int budget;
    addrPhase(addr, isWrite ? CMD_MEM_WRITE : CMD_MEM_READ);
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < waitBuf[i]; w++) begin
        bus.IRDY  = 1'b1;
        bus.AD_IN = $urandom;
        bus.C_BE  = 4'h0;
        tick();
      end
      bus.IRDY  = 1'b0;
      bus.FRAME = (i == n - 1);
      bus.AD_IN = isWrite ? wrData[i] : $urandom;
      bus.C_BE  = isWrite ? wrBe[i] : 4'h0;
      budget = 0;
      while (bus.TRDY !== 1'b0 && budget < 8) begin
        tick();
        budget++;
      end
      if (bus.TRDY !== 1'b0) begin
        timedOut = 1'b1;
        break;
      end
      rdBuf[i] = bus.AD_OUT;
      rdOe[i]  = bus.AD_OE;
      tick();
    end
    bus.FRAME = 1'b1;
    bus.IRDY  = 1'b1;
    doneA  = bus.DONE;
    devA   = bus.DEVSEL;
    devOeA = bus.DEVSEL_OE;
    tick();
    doneB   = bus.DONE;
    devOeB  = bus.DEVSEL_OE;
    trdyOeB = bus.TRDY_OE;
    adOeB   = bus.AD_OE;
    compared++;
    if (timedOut) begin
      mismatched++;
      $display("[TB] FAIL burst_timeout: TRDY never low at addr %h, required low within 8 cycles", addr);
    end
  endtask

  // Unclaimed transaction of n data phases; anyOe tracks any driven output
  task automatic applyMiss(input logic [31:0] addr, input logic [3:0] cmd, input int n);
    addrPhase(addr, cmd);
    for (int i = 0; i < n; i++) begin
      bus.IRDY  = 1'b0;
      bus.FRAME = (i == n - 1);
      bus.AD_IN = $urandom;
      bus.C_BE  = 4'h0;
      tick();
    end
    bus.FRAME = 1'b1;
    bus.IRDY  = 1'b1;
    tick();
    tick();
  endtask

  // Model update: byte b written when its active-low enable is 0, word index wraps
  task automatic modelWrite(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (!wrBe[i][b]) model[(start + i) % WORDS][8*b +: 8] = wrData[i][8*b +: 8];
      end
    end
  endtask

  task automatic clearWaits();
    for (int i = 0; i < 16; i++) waitBuf[i] = 0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.FRAME = 1'b1; bus.IRDY = 1'b1; bus.C_BE = 4'h0; bus.AD_IN = '0;
    for (int i = 0; i < WORDS; i++) model[i] = '0;
    repeat (2) @(negedge CLK);
    compared++;
    if (bus.AD_OUT !== 32'h0 || bus.AD_OE !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ad: got AD_OUT=%h AD_OE=%b, required 0/0", bus.AD_OUT, bus.AD_OE);
    end
    compared++;
    if ({bus.TRDY, bus.TRDY_OE, bus.DEVSEL, bus.DEVSEL_OE} !== 4'b1010) begin
      mismatched++;
      $display("[TB] FAIL reset_ctl: got TRDY/OE DEVSEL/OE=%b, required 1010",
               {bus.TRDY, bus.TRDY_OE, bus.DEVSEL, bus.DEVSEL_OE});
    end
    compared++;
    if (bus.DONE !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_done: got %b, required 0", bus.DONE);
    end
    RST = 1'b0;
    clearWaits();
    applyBurst(BASE, 1'b0, 4);
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (rdBuf[i] !== 32'h0) begin
        mismatched++;
        $display("[TB] FAIL reset_mem[%0d]: got %h, required 00000000", i, rdBuf[i]);
      end
    end
  endtask

  task automatic test_single();
    clearWaits();
    wrData[0] = 32'hDEAD_BEEF; wrBe[0] = 4'b0000;
    applyBurst(32'h0000_1008, 1'b1, 1);
    modelWrite(2, 1);
    compared++;
    if (trdyLat !== 1 || devLat !== 1) begin
      mismatched++;
      $display("[TB] FAIL write_latency: got TRDY@%0d DEVSEL@%0d, required 1/1", trdyLat, devLat);
    end
    compared++;
    if ({doneA, devA, devOeA} !== 3'b111 || {doneB, devOeB, trdyOeB} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL write_turn: got DONE,DEVSEL,OE=%b then DONE,DEVSEL_OE,TRDY_OE=%b, required 111/000",
               {doneA, devA, devOeA}, {doneB, devOeB, trdyOeB});
    end
    applyBurst(32'h0000_1008, 1'b0, 1);
    compared++;
    if (rdBuf[0] !== 32'hDEAD_BEEF || rdOe[0] !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL read_single: got %h oe=%b, required deadbeef oe=1", rdBuf[0], rdOe[0]);
    end
    compared++;
    if (trdyLat !== 2 || devLat !== 1) begin
      mismatched++;
      $display("[TB] FAIL read_latency: got TRDY@%0d DEVSEL@%0d, required 2/1", trdyLat, devLat);
    end
    compared++;
    if ({doneA, devA, devOeA} !== 3'b111 || {doneB, devOeB, trdyOeB, adOeB} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL read_turn: got %b then %b, required 111/0000",
               {doneA, devA, devOeA}, {doneB, devOeB, trdyOeB, adOeB});
    end
  endtask

  task automatic test_burst_wait();
    clearWaits();
    for (int i = 0; i < 4; i++) begin
      wrData[i] = 32'(i + 1);
      wrBe[i]   = 4'b0000;
    end
    waitBuf[2] = 2;
    applyBurst(BASE, 1'b1, 4);
    modelWrite(0, 4);
    clearWaits();
    waitBuf[1] = 1;
    applyBurst(BASE, 1'b0, 4);
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (rdBuf[i] !== 32'(i + 1)) begin
        mismatched++;
        $display("[TB] FAIL burst_wait[%0d]: got %h, required %h", i, rdBuf[i], 32'(i + 1));
      end
    end
  endtask

  task automatic test_byte_enables();
    clearWaits();
    wrData[0] = 32'h1122_3344; wrBe[0] = 4'b0000;
    applyBurst(32'h0000_1014, 1'b1, 1);
    modelWrite(5, 1);
    wrData[0] = 32'hAABB_CCDD; wrBe[0] = 4'b1010;
    applyBurst(32'h0000_1014, 1'b1, 1);
    modelWrite(5, 1);
    applyBurst(32'h0000_1014, 1'b0, 1);
    compared++;
    if (rdBuf[0] !== 32'h11BB_33DD) begin
      mismatched++;
      $display("[TB] FAIL byte_enable: got %h, required 11bb33dd", rdBuf[0]);
    end
  endtask

  task automatic test_misses();
    logic [31:0] missAddr [5];
    logic [3:0]  missCmd  [5];
    missAddr[0] = 32'h0000_2000; missCmd[0] = CMD_MEM_WRITE;
    missAddr[1] = 32'h0000_1000; missCmd[1] = 4'b0010;
    missAddr[2] = 32'h0000_1002; missCmd[2] = CMD_MEM_WRITE;
    missAddr[3] = 32'h0000_0FFC; missCmd[3] = CMD_MEM_WRITE;
    missAddr[4] = 32'h0000_1040; missCmd[4] = CMD_MEM_READ;
    clearWaits();
    for (int i = 0; i < WORDS; i++) begin
      wrData[i] = $urandom;
      wrBe[i]   = 4'b0000;
    end
    applyBurst(BASE, 1'b1, WORDS);
    modelWrite(0, WORDS);
    for (int m = 0; m < 5; m++) begin
      applyMiss(missAddr[m], missCmd[m], 3);
      compared++;
      if (anyOe !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL miss_%0d: output enable seen for addr %h cmd %b, required none",
                 m, missAddr[m], missCmd[m]);
      end
    end
    applyBurst(BASE, 1'b0, WORDS);
    for (int i = 0; i < WORDS; i++) begin
      compared++;
      if (rdBuf[i] !== model[i]) begin
        mismatched++;
        $display("[TB] FAIL miss_mem[%0d]: got %h, required %h", i, rdBuf[i], model[i]);
      end
    end
  endtask

  task automatic test_wrap();
    clearWaits();
    for (int i = 0; i < 3; i++) begin
      wrData[i] = $urandom;
      wrBe[i]   = 4'b0000;
    end
    applyBurst(BASE + 32'h3C, 1'b1, 3);
    modelWrite(15, 3);
    applyBurst(BASE + 32'h3C, 1'b0, 3);
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (rdBuf[i] !== model[(15 + i) % WORDS] || rdBuf[i] !== wrData[i]) begin
        mismatched++;
        $display("[TB] FAIL wrap[%0d]: got %h, required %h", i, rdBuf[i], wrData[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      automatic int start = $urandom_range(0, WORDS - 1);
      automatic int n     = $urandom_range(1, 6);
      automatic bit wr    = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        waitBuf[i] = $urandom_range(0, 2);
        wrData[i]  = $urandom;
        wrBe[i]    = 4'($urandom_range(0, 15));
      end
      applyBurst(BASE + 32'(start * 4), wr, n);
      if (wr) begin
        modelWrite(start, n);
      end else begin
        for (int i = 0; i < n; i++) begin
          compared++;
          if (rdBuf[i] !== model[(start + i) % WORDS]) begin
            mismatched++;
            $display("[TB] FAIL random_read t%0d[%0d]: got %h, required %h",
                     t, i, rdBuf[i], model[(start + i) % WORDS]);
          end
        end
      end
      compared++;
      if (doneA !== 1'b1 || doneB !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL random_done t%0d: got %b%b, required 10", t, doneA, doneB);
      end
    end
  endtask

  task automatic test_reset_midburst();
    addrPhase(BASE, CMD_MEM_READ);
    bus.IRDY  = 1'b0;
    bus.FRAME = 1'b0;
    tick();
    tick();
    compared++;
    if ({bus.AD_OE, bus.TRDY_OE, bus.DEVSEL_OE} !== 3'b111) begin
      mismatched++;
      $display("[TB] FAIL midburst_pre: got OE=%b, required 111",
               {bus.AD_OE, bus.TRDY_OE, bus.DEVSEL_OE});
    end
    #1 RST = 1'b1;
    #1;
    compared++;
    if ({bus.AD_OE, bus.TRDY_OE, bus.DEVSEL_OE} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL midburst_reset: got OE=%b, required 000",
               {bus.AD_OE, bus.TRDY_OE, bus.DEVSEL_OE});
    end
    bus.FRAME = 1'b1;
    bus.IRDY  = 1'b1;
    for (int i = 0; i < WORDS; i++) model[i] = '0;
    @(negedge CLK);
    RST = 1'b0;
    clearWaits();
    wrData[0] = $urandom; wrBe[0] = 4'b0000;
    applyBurst(BASE + 32'h20, 1'b1, 1);
    modelWrite(8, 1);
    applyBurst(BASE + 32'h20, 1'b0, 2);
    compared++;
    if (rdBuf[0] !== model[8] || rdBuf[1] !== model[9] || trdyLat !== 2) begin
      mismatched++;
      $display("[TB] FAIL post_reset: got %h %h lat %0d, required %h %h lat 2",
               rdBuf[0], rdBuf[1], trdyLat, model[8], model[9]);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_burst_wait();
    test_byte_enables();
    test_misses();
    test_wrap();
    test_random();
    test_reset_midburst();
    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
